// File: rtl/noc_params.sv
// ----------------------------------------------------------------------------
// noc_params
// Shared router parameters: port count, virtual channels per port, and the
// bit widths derived from them. Imported by every router block.
// ----------------------------------------------------------------------------
package noc_params;

    localparam int PORT_NUM  = 5;
    localparam int PORT_SIZE = $clog2(PORT_NUM);
    localparam int VC_NUM    = 2;
    localparam int VC_SIZE   = $clog2(VC_NUM);

    typedef logic [PORT_SIZE-1:0] port_t;

endpackage : noc_params

// File: rtl/vc_allocator_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// N-way round-robin arbiter with its own priority pointer. The winner is the
// first requester found scanning upward from the pointer, wrapping N-1 -> 0.
// The pointer moves to (winner + 1) mod N only when the arbiter is enabled
// and some requester wins.
//
// Ports:
//   clk       in   clock
//   resetn    in   asynchronous active-low reset (pointer -> 0)
//   req_i     in   [N]  request vector
//   en_i      in   arbitration enable (e.g. a resource is free)
//   grant_o   out  [N]  one-hot grant, all zero when disabled or idle
//   winner_o  out  [W]  index of the scanned winner (valid when grant_o != 0)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N = 10,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] winner_o
);

    logic [W-1:0] r_ptr;
    logic [W-1:0] w_winner;
    logic [N-1:0] w_onehot;
    logic         w_found;
    int           w_idx;

    // Cyclic scan starting at the pointer; the first hit wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise the paths that skip the write would infer a latch.
        w_found  = 1'b0;
        w_winner = '0;
        w_onehot = '0;
        w_idx    = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && req_i[w_idx]) begin
                w_found         = 1'b1;
                w_winner        = W'(w_idx);
                w_onehot[w_idx] = 1'b1;
            end
        end
    end

    assign grant_o  = en_i ? w_onehot : '0;
    assign winner_o = w_winner;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values, independent of block order.
            r_ptr <= '0;
        end else if (en_i && w_found) begin
            r_ptr <= (int'(w_winner) == N - 1) ? '0 : w_winner + 1'b1;
        end
    end

endmodule : rr_arbiter

// File: rtl/vc_allocator.sv
// ----------------------------------------------------------------------------
// vc_allocator
// Router virtual channel allocator. For every output port, one round-robin
// arbiter picks an input VC among those requesting that output, and the
// lowest-index free downstream VC of that output is handed to the winner.
// Downstream VC ownership is tracked until the downstream router releases it.
// Requester index r = in_port*VC_NUM + vc; downstream VC index is
// p*VC_NUM + v for output p, VC v.
//
// Ports:
//   clk            in   clock
//   resetn         in   asynchronous active-low reset
//   request_i      in   [N]            vc_request from each input VC
//   out_port_i     in   [N*PORT_SIZE]  target output port per requester
//   release_i      in   [N]            downstream VC freed (1-cycle pulse)
//   grant_valid_o  out  [N]            vc_valid to each requester (1 cycle)
//   grant_vc_o     out  [N*VC_SIZE]    vc_new to each requester (held)
//   avail_o        out  [N]            downstream VC currently unowned
//   error_o        out  1              protocol violation seen last cycle
// ----------------------------------------------------------------------------
module vc_allocator
    import noc_params::*;
#(
    localparam int N     = PORT_NUM * VC_NUM,
    localparam int IDX_W = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [N-1:0]           request_i,
    input  logic [N*PORT_SIZE-1:0] out_port_i,
    input  logic [N-1:0]           release_i,
    output logic [N-1:0]           grant_valid_o,
    output logic [N*VC_SIZE-1:0]   grant_vc_o,
    output logic [N-1:0]           avail_o,
    output logic                   error_o
);

    // Registered state.
    logic [N-1:0]         r_avail;
    logic [N-1:0]         r_grant_valid;
    logic [N*VC_SIZE-1:0] r_grant_vc;
    logic                 r_error;

    // Per-output arbitration signals.
    logic [N-1:0]         w_cand      [PORT_NUM];
    logic [N-1:0]         w_arb_grant [PORT_NUM];
    logic [IDX_W-1:0]     w_winner    [PORT_NUM];
    logic [VC_SIZE-1:0]   w_free_vc   [PORT_NUM];
    logic [PORT_NUM-1:0]  w_has_free;
    logic [PORT_NUM-1:0]  w_alloc;

    // Next-state values.
    logic [N-1:0]         w_avail_nxt;
    logic [N-1:0]         w_gv_nxt;
    logic [N*VC_SIZE-1:0] w_gvc_nxt;
    logic                 w_err_nxt;

    // Candidates: requesting this output and not currently being presented a
    // grant (the input buffer still holds its request during that cycle).
    // A port code >= PORT_NUM matches no output, so such requesters never win.
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            w_cand[p] = '0;
            for (int r = 0; r < N; r++) begin
                w_cand[p][r] = request_i[r]
                             && (out_port_i[r*PORT_SIZE +: PORT_SIZE] == port_t'(p))
                             && !r_grant_valid[r];
            end
        end
    end

    // Free-VC priority encoder per output: lowest available index wins, so
    // the scan runs downward and the last hit overrides.
    always_comb begin
        w_has_free = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            w_free_vc[p] = '0;
            for (int v = VC_NUM - 1; v >= 0; v--) begin
                if (r_avail[p*VC_NUM + v]) begin
                    w_has_free[p] = 1'b1;
                    w_free_vc[p]  = VC_SIZE'(v);
                end
            end
        end
    end

    // One arbiter per output; it only advances when a VC can actually be
    // handed out, so a stalled output keeps its fairness position.
    for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_arb
        rr_arbiter #(.N(N)) u_arb (
            .clk      (clk),
            .resetn   (resetn),
            .req_i    (w_cand[gp]),
            .en_i     (w_has_free[gp]),
            .grant_o  (w_arb_grant[gp]),
            .winner_o (w_winner[gp])
        );
        assign w_alloc[gp] = |w_arb_grant[gp];
    end

    always_comb begin
        w_avail_nxt = r_avail;
        w_gv_nxt    = '0;
        w_gvc_nxt   = r_grant_vc;
        w_err_nxt   = 1'b0;

        // Releases take effect at the edge; they do not feed this cycle's
        // allocation. Releasing an unowned VC is a protocol error.
        for (int i = 0; i < N; i++) begin
            if (release_i[i]) begin
                if (r_avail[i]) begin
                    w_err_nxt = 1'b1;
                end
                w_avail_nxt[i] = 1'b1;
            end
        end

        // Allocation is applied after releases: if a bogus release hits the
        // VC being allocated, the new owner keeps it.
        for (int p = 0; p < PORT_NUM; p++) begin
            if (w_alloc[p]) begin
                w_avail_nxt[p*VC_NUM + int'(w_free_vc[p])]           = 1'b0;
                w_gv_nxt                                            = w_gv_nxt | w_arb_grant[p];
                w_gvc_nxt[int'(w_winner[p])*VC_SIZE +: VC_SIZE]     = w_free_vc[p];
            end
        end

        for (int r = 0; r < N; r++) begin
            if (request_i[r] && (int'(out_port_i[r*PORT_SIZE +: PORT_SIZE]) >= PORT_NUM)) begin
                w_err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_avail       <= '1;
            r_grant_valid <= '0;
            r_grant_vc    <= '0;
            r_error       <= 1'b0;
        end else begin
            r_avail       <= w_avail_nxt;
            r_grant_valid <= w_gv_nxt;
            r_grant_vc    <= w_gvc_nxt;
            r_error       <= w_err_nxt;
        end
    end

    assign grant_valid_o = r_grant_valid;
    assign grant_vc_o    = r_grant_vc;
    assign avail_o       = r_avail;
    assign error_o       = r_error;

endmodule : vc_allocator

// File: tb/tb_vc_allocator.sv
// ----------------------------------------------------------------------------
// tb_vc_allocator
// Directed bench for vc_allocator (PORT_NUM=5, VC_NUM=2, N=10). Inputs are
// driven 1 time unit after a rising edge; outputs are read at the same point,
// so a value read after a tick reflects what was sampled at that edge.
// ----------------------------------------------------------------------------
module tb_vc_allocator;
    import noc_params::*;

    localparam int N = PORT_NUM * VC_NUM;

    logic                   clk;
    logic                   resetn;
    logic [N-1:0]           request_i;
    logic [N*PORT_SIZE-1:0] out_port_i;
    logic [N-1:0]           release_i;
    logic [N-1:0]           grant_valid_o;
    logic [N*VC_SIZE-1:0]   grant_vc_o;
    logic [N-1:0]           avail_o;
    logic                   error_o;

    int vectors;
    int miscompares;

    vc_allocator dut (
        .clk           (clk),
        .resetn        (resetn),
        .request_i     (request_i),
        .out_port_i    (out_port_i),
        .release_i     (release_i),
        .grant_valid_o (grant_valid_o),
        .grant_vc_o    (grant_vc_o),
        .avail_o       (avail_o),
        .error_o       (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int r, input int p);
        out_port_i[r*PORT_SIZE +: PORT_SIZE] = PORT_SIZE'(p);
    endtask

    function automatic int vc_of(input int r);
        return int'(grant_vc_o[r*VC_SIZE +: VC_SIZE]);
    endfunction

    task automatic do_reset();
        resetn     = 1'b0;
        request_i  = '0;
        out_port_i = '0;
        release_i  = '0;
        tick();
        tick();
        #2 resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (avail_o !== 10'h3FF) begin
            $display("FAIL reset_avail: got %h want 3ff", avail_o);
            miscompares++;
        end
        vectors++;
        if (grant_valid_o !== 10'h000 || grant_vc_o !== '0) begin
            $display("FAIL reset_grant: got valid=%h vc=%h want 000/0", grant_valid_o, grant_vc_o);
            miscompares++;
        end
        vectors++;
        if (error_o !== 1'b0) begin
            $display("FAIL reset_error: got %b want 0", error_o);
            miscompares++;
        end

        // Reset asserted while a grant is being presented.
        request_i[0] = 1'b1;
        set_port(0, 1);
        tick();
        vectors++;
        if (grant_valid_o !== 10'h001) begin
            $display("FAIL midreset_pre: got valid=%h want 001", grant_valid_o);
            miscompares++;
        end
        resetn = 1'b0;
        #1;
        vectors++;
        if (grant_valid_o !== 10'h000 || avail_o !== 10'h3FF || error_o !== 1'b0) begin
            $display("FAIL midreset_async: got valid=%h avail=%h err=%b want 000/3ff/0",
                     grant_valid_o, avail_o, error_o);
            miscompares++;
        end
        request_i = '0;
        out_port_i = '0;
        #2 resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        request_i[0] = 1'b1;
        set_port(0, 1);
        tick();
        vectors++;
        if (grant_valid_o !== 10'h001 || vc_of(0) != 0 || avail_o !== 10'h3FB) begin
            $display("FAIL single_grant: got valid=%h vc=%0d avail=%h want 001/0/3fb",
                     grant_valid_o, vc_of(0), avail_o);
            miscompares++;
        end
        tick();  // request still held: this cycle is masked
        vectors++;
        if (grant_valid_o !== 10'h000 || avail_o !== 10'h3FB) begin
            $display("FAIL single_masked: got valid=%h avail=%h want 000/3fb",
                     grant_valid_o, avail_o);
            miscompares++;
        end
        request_i = '0;
        release_i[2] = 1'b1;
        tick();
        release_i = '0;
        vectors++;
        if (avail_o !== 10'h3FF || error_o !== 1'b0) begin
            $display("FAIL single_release: got avail=%h err=%b want 3ff/0", avail_o, error_o);
            miscompares++;
        end
    endtask

    task automatic test_contention();
        do_reset();
        request_i = 10'b00_0001_0101;  // r0, r2, r4
        set_port(0, 1);
        set_port(2, 1);
        set_port(4, 1);
        tick();
        vectors++;
        if (grant_valid_o !== 10'h001 || vc_of(0) != 0 || avail_o !== 10'h3FB) begin
            $display("FAIL cont_r0: got valid=%h vc=%0d avail=%h want 001/0/3fb",
                     grant_valid_o, vc_of(0), avail_o);
            miscompares++;
        end
        request_i[0] = 1'b0;
        tick();
        vectors++;
        if (grant_valid_o !== 10'h004 || vc_of(2) != 1 || avail_o !== 10'h3F3) begin
            $display("FAIL cont_r2: got valid=%h vc=%0d avail=%h want 004/1/3f3",
                     grant_valid_o, vc_of(2), avail_o);
            miscompares++;
        end
        request_i[2] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (grant_valid_o !== 10'h000 || error_o !== 1'b0) begin
                $display("FAIL cont_stall%0d: got valid=%h err=%b want 000/0",
                         i, grant_valid_o, error_o);
                miscompares++;
            end
        end
        release_i[2] = 1'b1;
        tick();  // release edge: VC freed but not grantable yet
        release_i = '0;
        vectors++;
        if (grant_valid_o !== 10'h000 || avail_o !== 10'h3F7) begin
            $display("FAIL cont_nobypass: got valid=%h avail=%h want 000/3f7",
                     grant_valid_o, avail_o);
            miscompares++;
        end
        tick();
        vectors++;
        if (grant_valid_o !== 10'h010 || vc_of(4) != 0 || avail_o !== 10'h3F3) begin
            $display("FAIL cont_r4: got valid=%h vc=%0d avail=%h want 010/0/3f3",
                     grant_valid_o, vc_of(4), avail_o);
            miscompares++;
        end
        request_i = '0;
        release_i = 10'h00C;
        tick();
        release_i = '0;
        vectors++;
        if (avail_o !== 10'h3FF || error_o !== 1'b0) begin
            $display("FAIL cont_cleanup: got avail=%h err=%b want 3ff/0", avail_o, error_o);
            miscompares++;
        end
    endtask

    task automatic test_round_robin();
        int exp_r   [4] = '{0, 2, 0, 2};
        int exp_vc  [4] = '{0, 1, 0, 1};
        int rel_idx [4] = '{6, 7, 6, 7};
        request_i = 10'b00_0000_0101;
        set_port(0, 3);
        set_port(2, 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            release_i = '0;
            vectors++;
            if (grant_valid_o !== (10'h001 << exp_r[i]) || vc_of(exp_r[i]) != exp_vc[i]) begin
                $display("FAIL rr_grant%0d: got valid=%h vc=%0d want r%0d vc%0d",
                         i, grant_valid_o, vc_of(exp_r[i]), exp_r[i], exp_vc[i]);
                miscompares++;
            end
            release_i[rel_idx[i]] = 1'b1;
        end
        request_i = '0;
        tick();
        release_i = '0;
        vectors++;
        if (avail_o !== 10'h3FF || grant_valid_o !== 10'h000 || error_o !== 1'b0) begin
            $display("FAIL rr_cleanup: got avail=%h valid=%h err=%b want 3ff/000/0",
                     avail_o, grant_valid_o, error_o);
            miscompares++;
        end
    endtask

    task automatic test_parallel();
        request_i = 10'b00_0000_0101;
        set_port(0, 1);
        set_port(2, 2);
        tick();
        vectors++;
        if (grant_valid_o !== 10'h005 || vc_of(0) != 0 || vc_of(2) != 0 || avail_o !== 10'h3EB) begin
            $display("FAIL parallel: got valid=%h vc0=%0d vc2=%0d avail=%h want 005/0/0/3eb",
                     grant_valid_o, vc_of(0), vc_of(2), avail_o);
            miscompares++;
        end
        request_i = '0;
        release_i = 10'h014;
        tick();
        release_i = '0;
        vectors++;
        if (avail_o !== 10'h3FF || error_o !== 1'b0) begin
            $display("FAIL parallel_cleanup: got avail=%h err=%b want 3ff/0", avail_o, error_o);
            miscompares++;
        end
    endtask

    task automatic test_errors();
        release_i[0] = 1'b1;
        tick();
        release_i = '0;
        vectors++;
        if (error_o !== 1'b1 || avail_o !== 10'h3FF) begin
            $display("FAIL err_release: got err=%b avail=%h want 1/3ff", error_o, avail_o);
            miscompares++;
        end
        tick();
        vectors++;
        if (error_o !== 1'b0) begin
            $display("FAIL err_release_pulse: got err=%b want 0", error_o);
            miscompares++;
        end
        request_i[5] = 1'b1;
        set_port(5, 7);
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (error_o !== 1'b1 || grant_valid_o !== 10'h000 || avail_o !== 10'h3FF) begin
                $display("FAIL err_badport%0d: got err=%b valid=%h avail=%h want 1/000/3ff",
                         i, error_o, grant_valid_o, avail_o);
                miscompares++;
            end
        end
        request_i = '0;
        tick();
        vectors++;
        if (error_o !== 1'b0) begin
            $display("FAIL err_badport_clear: got err=%b want 0", error_o);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        request_i   = '0;
        out_port_i  = '0;
        release_i   = '0;

        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_parallel();
        test_errors();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_vc_allocator
